// File: rtl/wait_scheduler.sv
// wait_scheduler: per-bus-cycle Z80 /WAIT generator for the VG8020 bus.
// A new memory or IO cycle latches the lowest selected requester. Its
// programmed wait count (plus the M1 extra on opcode fetches) is inserted
// first, then the requester's own active-low WAIT line is honoured.
// Optional build macro: WAIT_SCHED_TIMEOUT_EN bounds the external hold to
// TIMEOUT cycles and raises a sticky timeout flag when it expires.
module wait_scheduler #(
  parameter int N_REQ    = 4,
  parameter int CNT_W    = 4,
  parameter int M1_EXTRA = 1,
  parameter int TIMEOUT  = 255,
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nm1,
  input  logic             nmreq,
  input  logic             niorq,
  input  logic             nrfsh,
  input  logic [N_REQ-1:0] sel,
  input  logic [N_REQ-1:0] nextwait,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_io,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             nwait,
  output logic             busy,
  output logic [IDX_W-1:0] active_idx,
  output logic             timeout
);

  localparam logic [CNT_W:0] M1X = (CNT_W + 1)'(M1_EXTRA);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] mem_tbl [N_REQ];
  logic [CNT_W-1:0] io_tbl  [N_REQ];
  logic             prev_idle;
  logic             sel_valid;
  logic [CNT_W:0]   cnt;

  logic             strobe_idle;
  logic             is_refresh;
  logic             is_inta;
  logic             start;
  logic             start_valid;
  logic [IDX_W-1:0] start_idx;
  logic [CNT_W-1:0] entry;
  logic [CNT_W:0]   total;
  logic             start_held;
  logic             cur_held;

`ifdef WAIT_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] HOLD_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] hold_cnt;
  logic            timeout_q;
`endif

  assign strobe_idle = nmreq & niorq;
  assign is_refresh  = ~nmreq & ~nrfsh;
  assign is_inta     = ~nm1 & ~niorq;
  assign start       = (state == IDLE) && prev_idle && !strobe_idle &&
                       !is_refresh && !is_inta;

  // Priority pick of the lowest-numbered selected requester.
  always_comb begin
    start_valid = 1'b0;
    start_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (sel[i]) begin
        start_valid = 1'b1;
        start_idx   = IDX_W'(i);
      end
    end
  end

  // Programmed wait for the cycle being started; an IO strobe selects the IO entry.
  always_comb begin
    entry = '0;
    if (start_valid) begin
      entry = (~niorq) ? io_tbl[start_idx] : mem_tbl[start_idx];
    end
    total = {1'b0, entry} + ((~nm1) ? M1X : '0);
  end

  assign start_held = start_valid && !nextwait[start_idx];
  assign cur_held   = sel_valid && !nextwait[active_idx];
  assign busy       = (state != IDLE);

`ifdef WAIT_SCHED_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Wait table, strobe history and the per-cycle WAIT state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      nwait      <= 1'b1;
      active_idx <= '0;
      sel_valid  <= 1'b0;
      cnt        <= '0;
      prev_idle  <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        mem_tbl[i] <= '0;
        io_tbl[i]  <= '0;
      end
`ifdef WAIT_SCHED_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      prev_idle <= strobe_idle;

      if (cfg_we && (int'(cfg_idx) < N_REQ)) begin
        if (cfg_io) begin
          io_tbl[cfg_idx] <= cfg_data;
        end else begin
          mem_tbl[cfg_idx] <= cfg_data;
        end
      end

      case (state)
        IDLE: begin
          nwait <= 1'b1;
          if (start) begin
            active_idx <= start_idx;
            sel_valid  <= start_valid;
            if (total != '0) begin
              state <= COUNT;
              cnt   <= total - 1'b1;
              nwait <= 1'b0;
            end else if (start_held) begin
              state <= HOLD;
              nwait <= 1'b0;
`ifdef WAIT_SCHED_TIMEOUT_EN
              hold_cnt <= '0;
`endif
            end else begin
              state <= DONE;
            end
          end
        end

        COUNT: begin
          if (strobe_idle) begin
            state <= IDLE;
            nwait <= 1'b1;
          end else if (cnt == '0) begin
            if (cur_held) begin
              state <= HOLD;
              nwait <= 1'b0;
`ifdef WAIT_SCHED_TIMEOUT_EN
              hold_cnt <= '0;
`endif
            end else begin
              state <= DONE;
              nwait <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        HOLD: begin
          if (strobe_idle) begin
            state <= IDLE;
            nwait <= 1'b1;
          end else if (!cur_held) begin
            state <= DONE;
            nwait <= 1'b1;
`ifdef WAIT_SCHED_TIMEOUT_EN
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= DONE;
            nwait     <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end

        DONE: begin
          nwait <= 1'b1;
          if (strobe_idle) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          nwait <= 1'b1;
        end
      endcase
    end
  end

endmodule
